data_cache: RTL and testbench
=============================

# data_cache

Direct-mapped, write-through, no-write-allocate data cache between the single-cycle core's load/store port and a multi-cycle backing memory. It responds to core word requests carrying per-byte write enables and serves read hits with one-cycle latency. Misses and all writes are forwarded to the memory side through a valid/ready request channel and a response-valid return channel. Returned words are full 32-bit words; the downstream load decoder performs byte and halfword extraction.

## Interface
- DATA_WIDTH, 32, word width
- ADDRESS_WIDTH, 32, byte address width; bits [1:0] ignored
- INDEX_WIDTH, 3, line index width (2^INDEX_WIDTH one-word lines); tag = A[ADDRESS_WIDTH-1:INDEX_WIDTH+2]

Ports:
- CLK  in  1  clock; all state updates on rising edge
- RST  in  1  asynchronous, active-high reset
- ReqValid  in  1  core request present
- ReqReady  out  1  block accepts a request this cycle; request accepted when ReqValid && ReqReady at the edge
- ReqWrite  in  1  1 = store, 0 = load
- A  in  ADDRESS_WIDTH  byte address
- WD  in  DATA_WIDTH  store data
- WE0, WE1, WE2, WE3  in  1 each  byte-lane enables for stores (WE0 = bits [7:0])
- RspValid  out  1  one-cycle pulse: load data valid or store complete
- RD  out  DATA_WIDTH  load data; valid only while RspValid=1
- MemReqValid  out  1  memory request present
- MemReady  in  1  memory accepts request when MemReqValid && MemReady at the edge
- MemReqWrite  out  1  1 = write, 0 = read
- MemAddr  out  ADDRESS_WIDTH  word-aligned address (bits [1:0] = 0)
- MemWD  out  DATA_WIDTH  write data
- MemBE  out  4  byte enables {WE3,WE2,WE1,WE0}
- MemRspValid  in  1  read data returning
- MemRD  in  DATA_WIDTH  read data

## Operation
- Per line: valid bit, tag, data word. FSM states: IDLE, REFILL_REQ, REFILL_WAIT, WRITE_REQ.
- IDLE: ReqReady=1. On acceptance, latch address, data and enables.
  - Read hit (valid && tag match): register line data into RD; RspValid=1 next cycle; stay in IDLE.
  - Read miss: go to REFILL_REQ.
  - Write: on hit, merge enabled bytes into line data at the acceptance edge; on miss, leave the line untouched (no allocate). Go to WRITE_REQ.
- REFILL_REQ: MemReqValid=1, MemReqWrite=0, MemAddr = latched word address. On MemReady, go to REFILL_WAIT.
- REFILL_WAIT: MemReqValid=0. On MemRspValid, write line (valid=1, tag, MemRD), RD<=MemRD, RspValid=1 next cycle, go to IDLE.
- WRITE_REQ: MemReqValid=1, MemReqWrite=1, MemWD and MemBE from the latched values. On MemReady, RspValid=1 next cycle (RD=0), go to IDLE.
- ReqReady=0 in all non-IDLE states; the core holds its request stable until acceptance.
- Memory-side outputs hold stable while MemReqValid=1 && MemReady=0.
- MemRspValid outside REFILL_WAIT is ignored. MemReady outside REFILL_REQ/WRITE_REQ is ignored.
- Store with all WE=0 is still forwarded to memory; the line is unchanged.

## Timing
- Reset (asynchronous, immediate): state=IDLE, all valid bits=0, RspValid=0, RD=0, MemReqValid=0, MemReqWrite=0, MemAddr=0, MemWD=0, MemBE=0. ReqReady=1 once RST deasserts. Data and tag arrays are not cleared.
- Reset mid-refill or mid-write aborts the transaction, with no response to the core. A late MemRspValid is ignored.
- Read hit: accepted at edge N, RspValid high in cycle N+1. Back-to-back hits sustain one per cycle.
- Read miss: accepted at edge N, MemReqValid high from cycle N+1. If memory accepts at edge M and responds at edge R, RspValid is high in cycle R+1.
- Write: accepted at edge N, MemReqValid from N+1; accepted by memory at edge M, RspValid high in cycle M+1.
- A read immediately following a write-hit response sees the merged data.

## Test plan
- After reset, read 0x40: MemReqValid, MemAddr=0x40, MemReqWrite=0. Return MemRD=0xDEADBEEF after 3 cycles, giving RspValid with RD=0xDEADBEEF. A second read of 0x40 gives RspValid with no MemReqValid.
- Conflict: after the 0x40 fill, read 0x60 (same index 0), which misses and refills with 0xCAFEF00D. Reading 0x40 again misses.
- Write hit to 0x40 (holding 0xDEADBEEF), WD=0x12345678, WE={0,0,1,1}: MemReqWrite=1, MemBE=0011. A following read of 0x40 hits and returns 0xDEAD5678.
- Write miss to 0x80 with WE=1111, WD=0x11111111: memory write issued. A following read of 0x80 misses.
- Hold MemReady=0 for 5 cycles in REFILL_REQ: MemReqValid, MemAddr and MemReqWrite remain stable and ReqReady=0 throughout. Response timing is correct after MemReady=1.
- Assert RST in REFILL_WAIT: outputs go to reset values immediately. A MemRspValid 2 cycles later produces no RspValid and no line fill, and a subsequent read of the same address misses.

Source files
------------

// File: rtl/data_cache.sv
// data_cache
//   Direct-mapped, write-through, no-write-allocate data cache that sits between
//   a single-cycle core load/store port and a multi-cycle backing memory.
//   Each of the 2^INDEX_WIDTH lines holds one word, its tag and a valid bit.
//   Read hits respond one cycle after acceptance. Read misses refill the line
//   from memory. Every store is forwarded to memory, and a store that hits also
//   merges its enabled bytes into the cached word.
//
// Ports
//   CLK, RST          clock; asynchronous active-high reset
//   ReqValid/ReqReady core request handshake (accepted when both are high)
//   ReqWrite, A, WD   store flag, byte address, store data
//   WE0..WE3          store byte-lane enables (WE0 = bits [7:0])
//   RspValid, RD      one-cycle response pulse; load data (0 for stores)
//   MemReqValid/MemReady      memory request handshake
//   MemReqWrite, MemAddr, MemWD, MemBE   memory request fields
//   MemRspValid, MemRD        refill data returning from memory
module data_cache #(
    parameter int DATA_WIDTH    = 32,
    parameter int ADDRESS_WIDTH = 32,
    parameter int INDEX_WIDTH   = 3
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic                     ReqValid,
    output logic                     ReqReady,
    input  logic                     ReqWrite,
    input  logic [ADDRESS_WIDTH-1:0] A,
    input  logic [DATA_WIDTH-1:0]    WD,
    input  logic                     WE0,
    input  logic                     WE1,
    input  logic                     WE2,
    input  logic                     WE3,
    output logic                     RspValid,
    output logic [DATA_WIDTH-1:0]    RD,
    output logic                     MemReqValid,
    input  logic                     MemReady,
    output logic                     MemReqWrite,
    output logic [ADDRESS_WIDTH-1:0] MemAddr,
    output logic [DATA_WIDTH-1:0]    MemWD,
    output logic [3:0]               MemBE,
    input  logic                     MemRspValid,
    input  logic [DATA_WIDTH-1:0]    MemRD
);

    localparam int LINES  = 1 << INDEX_WIDTH;
    localparam int TAG_W  = ADDRESS_WIDTH - INDEX_WIDTH - 2;
    localparam int LANE_W = DATA_WIDTH / 4;

    typedef enum logic [1:0] {
        S_IDLE,
        S_REFILL_REQ,
        S_REFILL_WAIT,
        S_WRITE_REQ
    } state_t;

    state_t                  r_state;
    logic [LINES-1:0]        r_valid;
    logic [TAG_W-1:0]        r_tag  [LINES];
    logic [DATA_WIDTH-1:0]   r_data [LINES];
    logic [INDEX_WIDTH-1:0]  r_idx;
    logic [TAG_W-1:0]        r_tag_q;

    logic [INDEX_WIDTH-1:0]  w_idx;
    logic [TAG_W-1:0]        w_tag;
    logic                    w_hit;
    logic                    w_accept;
    logic [3:0]              w_be;
    logic [ADDRESS_WIDTH-1:0] w_word_addr;
    logic [1:0]              w_unused_addr_lsb;

    // Replace only the byte lanes whose enable is set.
    function automatic logic [DATA_WIDTH-1:0] merge_bytes(
        input logic [DATA_WIDTH-1:0] old_word,
        input logic [DATA_WIDTH-1:0] new_word,
        input logic [3:0]            be
    );
        logic [DATA_WIDTH-1:0] result;
        result = old_word;
        for (int b = 0; b < 4; b++) begin
            if (be[b]) begin
                result[b*LANE_W +: LANE_W] = new_word[b*LANE_W +: LANE_W];
            end
        end
        return result;
    endfunction

    assign w_idx             = A[INDEX_WIDTH+1:2];
    assign w_tag             = A[ADDRESS_WIDTH-1:INDEX_WIDTH+2];
    assign w_hit             = r_valid[w_idx] && (r_tag[w_idx] == w_tag);
    assign w_be              = {WE3, WE2, WE1, WE0};
    assign w_word_addr       = {A[ADDRESS_WIDTH-1:2], 2'b00};
    assign w_unused_addr_lsb = A[1:0];

    // Held low while reset is asserted so nothing is accepted during reset.
    assign ReqReady = (r_state == S_IDLE) && !RST;
    assign w_accept = ReqValid && ReqReady;

    // Tag and data arrays carry no reset; the valid bits alone qualify them.
    // The two write sources are exclusive: acceptance happens only in IDLE.
    always_ff @(posedge CLK) begin
        if (w_accept && ReqWrite && w_hit) begin
            r_data[w_idx] <= merge_bytes(r_data[w_idx], WD, w_be);
        end else if ((r_state == S_REFILL_WAIT) && MemRspValid) begin
            r_data[r_idx] <= MemRD;
            r_tag[r_idx]  <= r_tag_q;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state     <= S_IDLE;
            r_valid     <= '0;
            r_idx       <= '0;
            r_tag_q     <= '0;
            RspValid    <= 1'b0;
            RD          <= '0;
            MemReqValid <= 1'b0;
            MemReqWrite <= 1'b0;
            MemAddr     <= '0;
            MemWD       <= '0;
            MemBE       <= '0;
        end else begin
            RspValid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_idx   <= w_idx;
                        r_tag_q <= w_tag;
                        if (ReqWrite) begin
                            // Write-through: every store goes out, hit or miss.
                            MemReqValid <= 1'b1;
                            MemReqWrite <= 1'b1;
                            MemAddr     <= w_word_addr;
                            MemWD       <= WD;
                            MemBE       <= w_be;
                            r_state     <= S_WRITE_REQ;
                        end else if (w_hit) begin
                            RD       <= r_data[w_idx];
                            RspValid <= 1'b1;
                        end else begin
                            MemReqValid <= 1'b1;
                            MemReqWrite <= 1'b0;
                            MemAddr     <= w_word_addr;
                            r_state     <= S_REFILL_REQ;
                        end
                    end
                end
                S_REFILL_REQ: begin
                    if (MemReady) begin
                        MemReqValid <= 1'b0;
                        r_state     <= S_REFILL_WAIT;
                    end
                end
                S_REFILL_WAIT: begin
                    if (MemRspValid) begin
                        r_valid[r_idx] <= 1'b1;
                        RD             <= MemRD;
                        RspValid       <= 1'b1;
                        r_state        <= S_IDLE;
                    end
                end
                S_WRITE_REQ: begin
                    if (MemReady) begin
                        MemReqValid <= 1'b0;
                        MemReqWrite <= 1'b0;
                        RD          <= '0;
                        RspValid    <= 1'b1;
                        r_state     <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_data_cache.sv
module tb_data_cache;

    logic        CLK = 1'b0;
    logic        RST;
    logic        ReqValid, ReqReady, ReqWrite;
    logic [31:0] A, WD;
    logic        WE0, WE1, WE2, WE3;
    logic        RspValid;
    logic [31:0] RD;
    logic        MemReqValid, MemReady, MemReqWrite;
    logic [31:0] MemAddr, MemWD;
    logic [3:0]  MemBE;
    logic        MemRspValid;
    logic [31:0] MemRD;

    int total = 0;
    int bad   = 0;

    data_cache dut (
        .CLK(CLK), .RST(RST),
        .ReqValid(ReqValid), .ReqReady(ReqReady), .ReqWrite(ReqWrite),
        .A(A), .WD(WD), .WE0(WE0), .WE1(WE1), .WE2(WE2), .WE3(WE3),
        .RspValid(RspValid), .RD(RD),
        .MemReqValid(MemReqValid), .MemReady(MemReady), .MemReqWrite(MemReqWrite),
        .MemAddr(MemAddr), .MemWD(MemWD), .MemBE(MemBE),
        .MemRspValid(MemRspValid), .MemRD(MemRD)
    );

    always #5 CLK = ~CLK;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    // Reference model: what the cache should hold, one word per index.
    logic        m_valid [8];
    logic [26:0] m_tag   [8];
    logic [31:0] m_data  [8];

    task automatic model_clear();
        for (int i = 0; i < 8; i++) m_valid[i] = 1'b0;
    endtask

    function automatic logic model_hit(input logic [31:0] addr);
        return m_valid[addr[4:2]] && (m_tag[addr[4:2]] == addr[31:5]);
    endfunction

    task automatic model_fill(input logic [31:0] addr, input logic [31:0] data);
        m_valid[addr[4:2]] = 1'b1;
        m_tag[addr[4:2]]   = addr[31:5];
        m_data[addr[4:2]]  = data;
    endtask

    task automatic model_write(input logic [31:0] addr, input logic [31:0] wd,
                               input logic [3:0] be);
        logic [31:0] mask;
        mask = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
        if (model_hit(addr))
            m_data[addr[4:2]] = (m_data[addr[4:2]] & ~mask) | (wd & mask);
    endtask

    // Observations of the last transaction.
    logic        t_hit, t_mseen, t_mwr, t_stable, t_rspok;
    logic [31:0] t_maddr, t_mwd, t_rd;
    logic [3:0]  t_mbe;

    // Drives one core request and plays the memory side; records what it saw.
    // Entered and left 1ns after a rising edge with the cache idle.
    task automatic xact(input logic wr, input logic [31:0] addr, input logic [31:0] wd,
                        input logic [3:0] be, input int stall, input int rsp_dly,
                        input logic [31:0] mdata);
        t_hit = 0; t_mseen = 0; t_mwr = 0; t_maddr = 0; t_mwd = 0; t_mbe = 0;
        t_stable = 1; t_rspok = 0; t_rd = 0;
        ReqValid = 1; ReqWrite = wr; A = addr; WD = wd;
        {WE3, WE2, WE1, WE0} = be;
        @(posedge CLK); #1;
        ReqValid = 0; ReqWrite = 0;
        if (RspValid && !MemReqValid) begin
            t_hit = 1; t_rspok = 1; t_rd = RD;
            return;
        end
        if (!MemReqValid) return;
        t_mseen = 1; t_mwr = MemReqWrite; t_maddr = MemAddr; t_mwd = MemWD; t_mbe = MemBE;
        for (int i = 0; i < stall; i++) begin
            @(posedge CLK); #1;
            if (!MemReqValid || MemReqWrite !== t_mwr || MemAddr !== t_maddr ||
                MemWD !== t_mwd || MemBE !== t_mbe || ReqReady !== 1'b0 || RspValid)
                t_stable = 0;
        end
        MemReady = 1;
        @(posedge CLK); #1;
        MemReady = 0;
        if (!t_mwr) begin
            if (MemReqValid || RspValid || ReqReady) t_stable = 0;
            for (int i = 0; i < rsp_dly; i++) begin
                @(posedge CLK); #1;
                if (MemReqValid || RspValid) t_stable = 0;
            end
            MemRspValid = 1; MemRD = mdata;
            @(posedge CLK); #1;
            MemRspValid = 0;
        end
        if (RspValid) begin
            t_rspok = 1; t_rd = RD;
        end
    endtask

    task automatic test_reset();
        RST = 1; ReqValid = 0; ReqWrite = 0; A = 0; WD = 0;
        {WE3, WE2, WE1, WE0} = 4'b0; MemReady = 0; MemRspValid = 0; MemRD = 0;
        repeat (2) @(posedge CLK);
        #1;
        total++; if (RspValid !== 1'b0) begin bad++; $display("FAIL reset_rspvalid: got %b want 0", RspValid); end
        total++; if (RD !== 32'h0) begin bad++; $display("FAIL reset_rd: got %h want 0", RD); end
        total++; if (MemReqValid !== 1'b0 || MemReqWrite !== 1'b0) begin bad++; $display("FAIL reset_memctl: got %b%b want 00", MemReqValid, MemReqWrite); end
        total++; if (MemAddr !== 32'h0 || MemWD !== 32'h0 || MemBE !== 4'h0) begin bad++; $display("FAIL reset_memfields: got %h %h %h want 0 0 0", MemAddr, MemWD, MemBE); end
        @(negedge CLK); RST = 0;
        @(posedge CLK); #1;
        total++; if (ReqReady !== 1'b1) begin bad++; $display("FAIL reset_reqready: got %b want 1", ReqReady); end
        model_clear();
    endtask

    task automatic test_read_fill();
        xact(0, 32'h40, 0, 4'h0, 0, 3, 32'hDEADBEEF);
        total++; if (!t_mseen || t_mwr !== 1'b0 || t_maddr !== 32'h40) begin bad++; $display("FAIL fill_memreq: got seen=%b wr=%b addr=%h want 1 0 00000040", t_mseen, t_mwr, t_maddr); end
        total++; if (!t_rspok || t_rd !== 32'hDEADBEEF) begin bad++; $display("FAIL fill_rsp: got ok=%b rd=%h want 1 deadbeef", t_rspok, t_rd); end
        total++; if (!t_stable) begin bad++; $display("FAIL fill_wait_quiet: got 0 want 1"); end
        @(posedge CLK); #1;
        total++; if (RspValid !== 1'b0) begin bad++; $display("FAIL fill_pulse: got %b want 0", RspValid); end
        model_fill(32'h40, 32'hDEADBEEF);
        xact(0, 32'h40, 0, 4'h0, 0, 0, 32'h0);
        total++; if (!t_hit || t_rd !== 32'hDEADBEEF) begin bad++; $display("FAIL fill_rehit: got hit=%b rd=%h want 1 deadbeef", t_hit, t_rd); end
    endtask

    task automatic test_conflict();
        xact(0, 32'h60, 0, 4'h0, 0, 1, 32'hCAFEF00D);
        total++; if (!t_mseen || t_maddr !== 32'h60 || t_rd !== 32'hCAFEF00D) begin bad++; $display("FAIL conflict_fill: got seen=%b addr=%h rd=%h want 1 00000060 cafef00d", t_mseen, t_maddr, t_rd); end
        model_fill(32'h60, 32'hCAFEF00D);
        xact(0, 32'h40, 0, 4'h0, 0, 2, 32'hDEADBEEF);
        total++; if (t_hit || !t_mseen || t_maddr !== 32'h40) begin bad++; $display("FAIL conflict_evict: got hit=%b seen=%b addr=%h want 0 1 00000040", t_hit, t_mseen, t_maddr); end
        model_fill(32'h40, 32'hDEADBEEF);
    endtask

    task automatic test_write_hit();
        xact(1, 32'h40, 32'h12345678, 4'b0011, 1, 0, 32'h0);
        total++; if (!t_mseen || t_mwr !== 1'b1 || t_maddr !== 32'h40 || t_mwd !== 32'h12345678 || t_mbe !== 4'b0011) begin bad++; $display("FAIL whit_memreq: got wr=%b addr=%h wd=%h be=%b want 1 00000040 12345678 0011", t_mwr, t_maddr, t_mwd, t_mbe); end
        total++; if (!t_rspok || t_rd !== 32'h0) begin bad++; $display("FAIL whit_rsp: got ok=%b rd=%h want 1 0", t_rspok, t_rd); end
        model_write(32'h40, 32'h12345678, 4'b0011);
        xact(0, 32'h40, 0, 4'h0, 0, 0, 32'h0);
        total++; if (!t_hit || t_rd !== 32'hDEAD5678) begin bad++; $display("FAIL whit_merge: got hit=%b rd=%h want 1 dead5678", t_hit, t_rd); end
    endtask

    task automatic test_write_miss();
        xact(1, 32'h80, 32'h11111111, 4'b1111, 0, 0, 32'h0);
        total++; if (!t_mseen || t_mwr !== 1'b1 || t_maddr !== 32'h80 || t_mbe !== 4'b1111 || !t_rspok) begin bad++; $display("FAIL wmiss_memreq: got seen=%b wr=%b addr=%h be=%b ok=%b want 1 1 00000080 1111 1", t_mseen, t_mwr, t_maddr, t_mbe, t_rspok); end
        xact(0, 32'h80, 0, 4'h0, 0, 0, 32'h0BADCAFE);
        total++; if (t_hit || !t_mseen || t_rd !== 32'h0BADCAFE) begin bad++; $display("FAIL wmiss_noalloc: got hit=%b seen=%b rd=%h want 0 1 0badcafe", t_hit, t_mseen, t_rd); end
        model_fill(32'h80, 32'h0BADCAFE);
        // Store with no lanes enabled still goes out but leaves the line alone.
        xact(1, 32'h80, 32'hFFFFFFFF, 4'b0000, 0, 0, 32'h0);
        total++; if (!t_mseen || t_mwr !== 1'b1 || t_mbe !== 4'b0000 || !t_rspok) begin bad++; $display("FAIL wzero_memreq: got seen=%b wr=%b be=%b ok=%b want 1 1 0000 1", t_mseen, t_mwr, t_mbe, t_rspok); end
        xact(0, 32'h80, 0, 4'h0, 0, 0, 32'h0);
        total++; if (!t_hit || t_rd !== 32'h0BADCAFE) begin bad++; $display("FAIL wzero_line: got hit=%b rd=%h want 1 0badcafe", t_hit, t_rd); end
    endtask

    task automatic test_mem_stall();
        logic [31:0] d;
        d = $urandom;
        xact(0, 32'h104, 0, 4'h0, 5, 2, d);
        total++; if (!t_stable) begin bad++; $display("FAIL stall_hold: got 0 want 1"); end
        total++; if (t_maddr !== 32'h104 || !t_rspok || t_rd !== d) begin bad++; $display("FAIL stall_rsp: got addr=%h ok=%b rd=%h want 00000104 1 %h", t_maddr, t_rspok, t_rd, d); end
        model_fill(32'h104, d);
    endtask

    task automatic test_back_to_back();
        logic [31:0] addrs [3];
        logic [31:0] datas [3];
        for (int i = 0; i < 3; i++) begin
            addrs[i] = 32'h400 + 32'(i * 4);
            datas[i] = $urandom;
            xact(0, addrs[i], 0, 4'h0, 0, 0, datas[i]);
            model_fill(addrs[i], datas[i]);
        end
        ReqValid = 1; ReqWrite = 0; A = addrs[0];
        for (int i = 0; i < 3; i++) begin
            @(posedge CLK); #1;
            if (i < 2) A = addrs[i+1];
            else ReqValid = 0;
            total++; if (RspValid !== 1'b1 || RD !== datas[i] || MemReqValid !== 1'b0 || ReqReady !== 1'b1) begin bad++; $display("FAIL b2b_hit%0d: got v=%b rd=%h mv=%b rr=%b want 1 %h 0 1", i, RspValid, RD, MemReqValid, ReqReady, datas[i]); end
        end
        @(posedge CLK); #1;
        total++; if (RspValid !== 1'b0) begin bad++; $display("FAIL b2b_end: got %b want 0", RspValid); end
    endtask

    task automatic test_reset_mid_refill();
        ReqValid = 1; ReqWrite = 0; A = 32'h300;
        @(posedge CLK); #1;
        ReqValid = 0;
        total++; if (MemReqValid !== 1'b1 || MemAddr !== 32'h300) begin bad++; $display("FAIL rmid_req: got v=%b addr=%h want 1 00000300", MemReqValid, MemAddr); end
        MemReady = 1;
        @(posedge CLK); #1;
        MemReady = 0;
        #2; RST = 1; #1;
        total++; if (MemReqValid !== 1'b0 || MemAddr !== 32'h0 || MemReqWrite !== 1'b0 || MemWD !== 32'h0 || MemBE !== 4'h0) begin bad++; $display("FAIL rmid_mem: got v=%b addr=%h wr=%b wd=%h be=%h want 0 0 0 0 0", MemReqValid, MemAddr, MemReqWrite, MemWD, MemBE); end
        total++; if (RspValid !== 1'b0 || RD !== 32'h0) begin bad++; $display("FAIL rmid_core: got v=%b rd=%h want 0 0", RspValid, RD); end
        #2; RST = 0;
        @(posedge CLK); #1;
        @(posedge CLK); #1;
        MemRspValid = 1; MemRD = 32'hBAD0BAD0;
        @(posedge CLK); #1;
        MemRspValid = 0;
        total++; if (RspValid !== 1'b0 || ReqReady !== 1'b1) begin bad++; $display("FAIL rmid_late: got v=%b rr=%b want 0 1", RspValid, ReqReady); end
        model_clear();
        xact(0, 32'h300, 0, 4'h0, 0, 0, 32'h13572468);
        total++; if (t_hit || !t_mseen || t_rd !== 32'h13572468) begin bad++; $display("FAIL rmid_refetch: got hit=%b seen=%b rd=%h want 0 1 13572468", t_hit, t_mseen, t_rd); end
        model_fill(32'h300, 32'h13572468);
    endtask

    task automatic test_random();
        logic        wr, exp_hit;
        logic [31:0] addr, wd, md, exp_rd, aligned;
        logic [3:0]  be;
        for (int n = 0; n < 200; n++) begin
            addr = (32'($urandom_range(0, 3)) << 12) | (32'($urandom_range(0, 7)) << 2)
                 | 32'($urandom_range(0, 3));
            aligned = {addr[31:2], 2'b00};
            wr = ($urandom_range(0, 9) < 3);
            wd = $urandom; md = $urandom; be = 4'($urandom);
            exp_hit = model_hit(addr);
            exp_rd  = m_data[addr[4:2]];
            xact(wr, addr, wd, be, $urandom_range(0, 3), $urandom_range(0, 3), md);
            if (!wr) begin
                total++; if (t_hit !== exp_hit) begin bad++; $display("FAIL rnd_hit[%0d]: addr=%h got %b want %b", n, addr, t_hit, exp_hit); end
                if (exp_hit) begin
                    total++; if (t_rd !== exp_rd) begin bad++; $display("FAIL rnd_hit_rd[%0d]: got %h want %h", n, t_rd, exp_rd); end
                end else begin
                    total++; if (t_maddr !== aligned || t_mwr !== 1'b0 || !t_rspok || t_rd !== md) begin bad++; $display("FAIL rnd_miss[%0d]: got addr=%h wr=%b ok=%b rd=%h want %h 0 1 %h", n, t_maddr, t_mwr, t_rspok, t_rd, aligned, md); end
                    model_fill(addr, md);
                end
            end else begin
                total++; if (!t_mseen || t_mwr !== 1'b1 || t_maddr !== aligned || t_mwd !== wd || t_mbe !== be) begin bad++; $display("FAIL rnd_wreq[%0d]: got wr=%b addr=%h wd=%h be=%b want 1 %h %h %b", n, t_mwr, t_maddr, t_mwd, t_mbe, aligned, wd, be); end
                total++; if (!t_rspok || t_rd !== 32'h0) begin bad++; $display("FAIL rnd_wrsp[%0d]: got ok=%b rd=%h want 1 0", n, t_rspok, t_rd); end
                model_write(addr, wd, be);
            end
            total++; if (!t_stable) begin bad++; $display("FAIL rnd_stable[%0d]: got 0 want 1", n); end
        end
    endtask

    initial begin
        test_reset();
        test_read_fill();
        test_conflict();
        test_write_hit();
        test_write_miss();
        test_mem_stall();
        test_back_to_back();
        test_reset_mid_refill();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
